truth_table_bist: RTL and testbench
===================================

# truth_table_bist

Synthesizable built-in self-test controller for 4-input single-output combinational blocks. It sweeps every input vector 0..15 in order, holds each vector for a settle window, and checks three parallel implementations (gate-level, dataflow, behavioural) against a golden truth table. It reports pass, or the first failing vector and which outputs failed. It is the on-chip counterpart of the simulation sweep used for the team's combinational exercises, and it sits between a start/status register interface and the three units under test.

## Interface
- `WIDTH`, 4: input vector width. Fixed at 4; other values are unsupported.
- `MINTERMS`, 16'hC0A0: golden truth table. Bit n is the expected output for vector n. The default sets minterms 5, 7, 14 and 15.
- `SETTLE`, 5: cycles each vector is held before sampling. Legal range 1..255.

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a sweep; sampled only in IDLE or DONE
- `out_g`  in  1  gate-level unit output
- `out_d`  in  1  dataflow unit output
- `out_b`  in  1  behavioural unit output
- `vec`  out  4  vector driven to all three units
- `busy`  out  1  high while a sweep is in progress
- `done`  out  1  high in DONE; held until the next start or reset
- `pass`  out  1  valid when done=1; 1 means all 16 vectors matched
- `fail_vec`  out  4  first failing vector; 0 when pass=1
- `fail_code`  out  3  mismatch flags {g,d,b} at fail_vec; 0 when pass=1

## Operation
- **Reset values:** state IDLE; vec, busy, done, pass, fail_vec and fail_code all 0; settle counter 0.
- **FSM states:** IDLE, APPLY, CHECK, DONE.
- **IDLE:** if start=1, go to APPLY with vec=0, settle counter cleared and busy=1.
- **APPLY:** vec is held constant. The counter increments each cycle. After SETTLE cycles in APPLY, go to CHECK.
- **CHECK:** one cycle.
  - Expected value: exp = MINTERMS[vec].
  - Mismatch flags: m = {out_g!=exp, out_d!=exp, out_b!=exp}.
  - If m≠0: go to DONE with pass=0, fail_vec=vec, fail_code=m.
  - If m=0 and vec=15: go to DONE with pass=1.
  - Otherwise: vec increments, counter clears, go to APPLY.
- Disagreement between the three units is always a mismatch, because at least one of them differs from exp.
- **DONE:** busy=0, done=1. vec holds its last value.
  - start=1 clears pass, fail_vec, fail_code and done.
  - Vec resets to 0 and the FSM enters APPLY, exactly as from IDLE.
- **start while busy:** ignored, with no effect on the sweep in progress.
- **Vector arithmetic:** vec increments only in CHECK and never wraps. The sweep ends at 15.
- **Settle counter:** 8 bits, unsigned.
- **Reset mid-sweep:** asynchronous return to IDLE with all outputs at their reset values. No partial result is retained.

## Timing
- Cycle numbering: the cycle in which start is sampled high is cycle 0.
- Vector k is driven from cycle k·(SETTLE+1)+1 through cycle (k+1)·(SETTLE+1).
  - The last of those cycles is CHECK.
  - The unit outputs are compared combinationally in that cycle and the result is registered at its closing edge.
- A failure at vector k gives done=1 from cycle (k+1)·(SETTLE+1)+1.
- A full pass gives done=1 from cycle 16·(SETTLE+1)+1, which is cycle 97 at SETTLE=5.
- busy rises at cycle 1 and falls in the same cycle that done rises.
- vec changes only at APPLY entry, so it is stable throughout each settle window.
- Outputs are registered, with no combinational path from inputs to outputs.
- out_g, out_d and out_b are assumed to settle within SETTLE cycles. They are not synchronized.

## Test plan
- **Correct units:** all three units model MINTERMS correctly; pulse start -> busy in cycles 1..96, done=1 and pass=1 at cycle 97, fail_vec=0, fail_code=0, vec=15.
- **Stuck-at-0 on out_d:** out_d stuck at 0, other units correct -> done at cycle 37, pass=0, fail_vec=5, fail_code=3'b010.
- **Extra minterm on out_g:** out_g also 1 for vector 0 -> done at cycle 7, fail_vec=0, fail_code=3'b100. Also, out_b inverted at vector 14 only -> fail_vec=14, fail_code=3'b001, done at cycle 91.
- **Reset mid-sweep:** assert rst at cycle 40 for 2 cycles -> all outputs 0 immediately. A new start then completes a full pass with done 97 cycles after that start.
- **Start while busy, then restart:** pulse start at cycles 10 and 20 -> sweep unaffected, done still at 97. A start in DONE after a failing run clears done, pass, fail_vec and fail_code on the next cycle and reruns the sweep.
- **Minimum settle:** SETTLE=1 with correct units -> each vector is held 2 cycles and done=1, pass=1 at cycle 33.

Source files
------------

// File: rtl/truth_table_bist.sv
// Purpose: BIST sweep of vectors 0..15 over three 4-input units, compared against a golden truth table.
// Latency: each vector is held SETTLE cycles and checked on the next one; done rises (k+1)*(SETTLE+1)+1 cycles after start.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while busy.
// Ports: clk/rst (async active-high); start; out_g/out_d/out_b from the units under test;
//        vec drives the units; busy/done/pass/fail_vec/fail_code report status (all registered).
module truth_table_bist #(
    parameter int          WIDTH    = 4,
    parameter logic [15:0] MINTERMS = 16'hC0A0,
    parameter int          SETTLE   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             out_g,
    input  logic             out_d,
    input  logic             out_b,
    output logic [WIDTH-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] fail_vec,
    output logic [2:0]       fail_code
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    // The counter starts at 0 on APPLY entry, so its last settle cycle holds SETTLE-1.
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [WIDTH-1:0] VEC_LAST    = '1;

    state_t     state;
    logic [7:0] settle_cnt;
    logic       exp_bit;
    logic [2:0] mism;

    // Sampled only in CHECK; vec has been stable for the whole settle window by then.
    assign exp_bit = MINTERMS[vec];
    assign mism    = {out_g != exp_bit, out_d != exp_bit, out_b != exp_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            fail_code  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // A restart from DONE wipes the previous result before the new sweep.
                    if (start) begin
                        state      <= APPLY;
                        vec        <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_vec   <= '0;
                        fail_code  <= '0;
                    end
                end
                APPLY: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mism != 3'b000) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_vec  <= vec;
                        fail_code <= mism;
                    end else if (vec == VEC_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else begin
                        state      <= APPLY;
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_bist.sv
// Bench for truth_table_bist: two instances (SETTLE=5 and SETTLE=1) share clk/rst/start.
// The units under test are modelled as golden table XOR a per-unit flip mask.
// Expected results come from a first-failing-vector search over the flip masks.
module tb_truth_table_bist;

    localparam logic [15:0] MT = 16'hC0A0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] flip_g, flip_d, flip_b;

    logic [3:0] vec0, vec1, fv0, fv1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [2:0] fc0, fc1;
    logic       g0, d0, b0, g1, d1, b1;

    assign g0 = MT[vec0] ^ flip_g[vec0];
    assign d0 = MT[vec0] ^ flip_d[vec0];
    assign b0 = MT[vec0] ^ flip_b[vec0];
    assign g1 = MT[vec1] ^ flip_g[vec1];
    assign d1 = MT[vec1] ^ flip_d[vec1];
    assign b1 = MT[vec1] ^ flip_b[vec1];

    truth_table_bist #(.WIDTH(4), .MINTERMS(MT), .SETTLE(5)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .out_g(g0), .out_d(d0), .out_b(b0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0), .fail_code(fc0)
    );

    truth_table_bist #(.WIDTH(4), .MINTERMS(MT), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .out_g(g1), .out_d(d1), .out_b(b1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .fail_code(fc1)
    );

    // Observed outputs of the instance currently under test.
    int         sel = 0;
    logic [3:0] o_vec, o_fv;
    logic       o_busy, o_done, o_pass;
    logic [2:0] o_fc;
    always_comb begin
        o_vec  = vec0;  o_fv = fv0;  o_busy = busy0;
        o_done = done0; o_pass = pass0; o_fc = fc0;
        if (sel != 0) begin
            o_vec  = vec1;  o_fv = fv1;  o_busy = busy1;
            o_done = done1; o_pass = pass1; o_fc = fc1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one sweep on instance `sel` and checks it against the reference search.
    task automatic run_sweep(input bit poke_busy);
        int   s, exp_k, exp_cyc, c, exp_vec;
        logic [2:0] exp_code, m;
        bit   seen, busy_ok, vec_ok, clr_ok;
        s = (sel == 0) ? 5 : 1;
        exp_k = -1;
        exp_code = 3'b000;
        for (int k = 0; k < 16; k++) begin
            m = {flip_g[k], flip_d[k], flip_b[k]};
            if (exp_k < 0 && m != 3'b000) begin
                exp_k = k;
                exp_code = m;
            end
        end
        exp_cyc = ((exp_k < 0) ? 16 : exp_k + 1) * (s + 1) + 1;
        exp_vec = (exp_k < 0) ? 15 : exp_k;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);                    // closing edge of cycle 0
        c = 0; seen = 0; busy_ok = 1; vec_ok = 1; clr_ok = 1;
        while (!seen && c < 300) begin
            @(negedge clk);
            c++;
            if (c == 1) start = 1'b0;
            if (poke_busy && (c == 10 || c == 20)) start = 1'b1;
            if (poke_busy && (c == 11 || c == 21)) start = 1'b0;
            if (o_done) begin
                seen = 1;
            end else begin
                if (!o_busy) busy_ok = 0;
                if (int'(o_vec) != (c - 1) / (s + 1)) vec_ok = 0;
                if (o_pass || o_fv != 4'd0 || o_fc != 3'd0) clr_ok = 0;
            end
        end
        start = 1'b0;
        chk("done_cycle", seen ? c : -1, exp_cyc);
        chk("busy_window", busy_ok, 1);
        chk("vec_schedule", vec_ok, 1);
        chk("result_cleared", clr_ok, 1);
        chk("busy_at_done", o_busy, 0);
        chk("pass", o_pass, exp_k < 0);
        chk("fail_vec", o_fv, (exp_k < 0) ? 0 : exp_k);
        chk("fail_code", o_fc, exp_code);
        chk("vec_final", o_vec, exp_vec);
        repeat (3) @(negedge clk);
        chk("done_hold", o_done, 1);
        chk("vec_hold", o_vec, exp_vec);
        // Let the other instance finish so the next start reaches both.
        c = 0;
        while ((busy0 || busy1) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("both_idle", busy0 | busy1, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        flip_g = '0; flip_d = '0; flip_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_vec", o_vec, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_fail_vec", o_fv, 0);
        chk("rst_fail_code", o_fc, 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct units.
        run_sweep(0);
        // out_d stuck at 0.
        flip_d = MT; run_sweep(0); flip_d = '0;
        // Extra minterm 0 on out_g.
        flip_g = 16'h0001; run_sweep(0); flip_g = '0;
        // out_b inverted at vector 14 (also a restart from a failed DONE).
        flip_b = 16'h4000; run_sweep(0); flip_b = '0;
        // Start pulses while busy are ignored.
        run_sweep(1);

        // Reset mid-sweep.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_vec", vec0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_result", {pass0, fv0, fc0}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sweep(0);

        // Minimum settle.
        sel = 1;
        run_sweep(0);

        // Randomised fault masks on either instance.
        for (int r = 0; r < 20; r++) begin
            sel = int'($urandom_range(0, 1));
            flip_g = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            flip_d = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            flip_b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            run_sweep(0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
